// File: rtl/frame_copy_dma.sv
// Streams one frame from the frame-store RAM into VRAM, one word per clock.
// Optional completed-copy counter enabled by FRAME_COPY_DMA_COUNT_EN.
module frame_copy_dma #(
  parameter int ADDR_BITS     = 12,
  parameter int FRAME_BITS    = 10,
  parameter int DATA_WIDTH    = 16,
  parameter int DST_ADDR_BITS = 16
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            START,
  input  logic [ADDR_BITS-FRAME_BITS-1:0] FRAME_SEL,
  input  logic                            ABORT,
  input  logic                            DST_READY,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            REJECT,
  output logic                            SRC_EN,
  output logic [ADDR_BITS-1:0]            SRC_ADDR,
  input  logic [DATA_WIDTH-1:0]           SRC_DATA,
  output logic                            DST_EN,
  output logic                            DST_WE,
  output logic [DST_ADDR_BITS-1:0]        DST_ADDR,
  output logic [DATA_WIDTH-1:0]           DST_DATA,
  output logic [15:0]                     COPY_COUNT
);

  localparam int FW = ADDR_BITS - FRAME_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [FW-1:0]              frame_q, frame_d;
  logic [FRAME_BITS-1:0]      off_q, off_d;
  logic                       src_en_q, src_en_d;
  logic                       dst_en_q, dst_en_d;
  logic [DST_ADDR_BITS-1:0]   dst_addr_q, dst_addr_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       reject_q, reject_d;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    off_d      = off_q;
    src_en_d   = 1'b0;
    dst_en_d   = 1'b0;
    dst_addr_d = dst_addr_q;
    done_d     = 1'b0;
    reject_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (DST_READY) begin
            frame_d  = FRAME_SEL;
            off_d    = '0;
            src_en_d = 1'b1;
            state_d  = STREAM;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (ABORT) begin
          state_d = IDLE;
        end else begin
          // write stage trails the read issued this cycle by one clock
          dst_en_d   = src_en_q;
          dst_addr_d = DST_ADDR_BITS'(off_q);
          if (off_q == {FRAME_BITS{1'b1}}) begin
            state_d = DRAIN;
          end else begin
            off_d    = off_q + 1'b1;
            src_en_d = 1'b1;
          end
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_d  = ~ABORT;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      off_q      <= '0;
      src_en_q   <= 1'b0;
      dst_en_q   <= 1'b0;
      dst_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      off_q      <= off_d;
      src_en_q   <= src_en_d;
      dst_en_q   <= dst_en_d;
      dst_addr_q <= dst_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
    end
  end

`ifdef FRAME_COPY_DMA_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (done_d && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign COPY_COUNT = cnt_q;
`else
  assign COPY_COUNT = '0;
`endif

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign REJECT   = reject_q;
  assign SRC_EN   = src_en_q;
  assign SRC_ADDR = {frame_q, off_q};
  assign DST_EN   = dst_en_q;
  assign DST_WE   = dst_en_q;
  assign DST_ADDR = dst_addr_q;
  assign DST_DATA = SRC_DATA;

endmodule

// File: tb/tb_frame_copy_dma.sv
// Directed bench for frame_copy_dma: full copies, reject, abort,
// back-to-back copies, async reset and the optional copy counter.
module tb_frame_copy_dma;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [1:0]  FRAME_SEL;
  logic        ABORT;
  logic        DST_READY;
  logic        BUSY;
  logic        DONE;
  logic        REJECT;
  logic        SRC_EN;
  logic [11:0] SRC_ADDR;
  logic [15:0] SRC_DATA;
  logic        DST_EN;
  logic        DST_WE;
  logic [15:0] DST_ADDR;
  logic [15:0] DST_DATA;
  logic [15:0] COPY_COUNT;

`ifdef FRAME_COPY_DMA_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  int checks = 0;
  int failures = 0;

  int rd_cnt, wr_cnt, rd_err, wr_err, dat_err;
  logic [11:0] exp_raddr;
  logic [15:0] exp_waddr;
  int fa, fb;

  frame_copy_dma dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .FRAME_SEL(FRAME_SEL), .ABORT(ABORT),
    .DST_READY(DST_READY), .BUSY(BUSY), .DONE(DONE),
    .REJECT(REJECT), .SRC_EN(SRC_EN),
    .SRC_ADDR(SRC_ADDR), .SRC_DATA(SRC_DATA),
    .DST_EN(DST_EN), .DST_WE(DST_WE),
    .DST_ADDR(DST_ADDR), .DST_DATA(DST_DATA),
    .COPY_COUNT(COPY_COUNT)
  );

  always #5 CLK = ~CLK;

  // frame-store model: word = {frame in the top nibble, offset}
  always @(posedge CLK)
    if (SRC_EN)
      SRC_DATA <= {2'b00, SRC_ADDR[11:10], 2'b00, SRC_ADDR[9:0]};

  always @(negedge CLK) begin
    int fr;
    if (SRC_EN) begin
      rd_cnt++;
      if (SRC_ADDR !== exp_raddr) rd_err++;
      exp_raddr = SRC_ADDR + 12'd1;
    end
    if (DST_EN || DST_WE) begin
      fr = (wr_cnt < 1024) ? fa : fb;
      if (!(DST_EN && DST_WE)) wr_err++;
      if (DST_ADDR !== exp_waddr) wr_err++;
      if (DST_DATA !== 16'(16'h1000 * fr + DST_ADDR)) dat_err++;
      exp_waddr = (DST_ADDR + 16'd1) & 16'h03FF;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic mon_clear(input int f0, input int f1, input int f);
    rd_cnt = 0; wr_cnt = 0; rd_err = 0; wr_err = 0; dat_err = 0;
    fa = f0; fb = f1;
    exp_raddr = 12'(f * 1024);
    exp_waddr = 16'h0;
  endtask

  // waits for DONE; returns cycles since accept edge (N+k)
  task automatic wait_done(output int k);
    k = 1;
    while (!DONE && k < 2000) begin
      tick();
      k++;
    end
  endtask

  task automatic do_copy(input int f, input string tag);
    int k;
    mon_clear(f, f, f);
    START = 1'b1; FRAME_SEL = 2'(f); DST_READY = 1'b1;
    tick();
    START = 1'b0;
    chk({tag, "_first"}, {BUSY, SRC_EN, 4'h0, SRC_ADDR},
        {1'b1, 1'b1, 4'h0, 12'(f * 1024)});
    wait_done(k);
    chk({tag, "_done_cyc"}, k, 1026);
    chk({tag, "_busy_at_done"}, BUSY, 0);
    chk({tag, "_rd_wr"}, {rd_cnt[15:0], wr_cnt[15:0]}, {16'd1024, 16'd1024});
    chk({tag, "_seq_err"}, rd_err + wr_err + dat_err, 0);
  endtask

  initial begin
    int k, bad;
    RESET = 1'b1; START = 1'b0; FRAME_SEL = 2'd0;
    ABORT = 1'b0; DST_READY = 1'b0;
    mon_clear(0, 0, 0);
    repeat (3) tick();
    chk("reset_outs", {BUSY, DONE, REJECT, SRC_EN, DST_EN, DST_WE},
        6'b0);
    chk("reset_addr", {SRC_ADDR, DST_ADDR, COPY_COUNT}, 44'h0);
    RESET = 1'b0;
    tick();

    do_copy(2, "f2");
    chk("cnt_after_one", COPY_COUNT, 32'(CNT_EN));
    tick();
    chk("done_pulse", DONE, 0);

    START = 1'b1; DST_READY = 1'b0;
    tick();
    START = 1'b0;
    chk("reject", {REJECT, BUSY, SRC_EN, DST_EN}, 4'b1000);
    tick();
    chk("reject_pulse", {REJECT, BUSY, SRC_EN, DST_EN}, 4'b0000);

    mon_clear(0, 0, 0);
    START = 1'b1; FRAME_SEL = 2'd0; DST_READY = 1'b1;
    tick();
    START = 1'b0;
    repeat (50) tick();
    #2 RESET = 1'b1;
    #1;
    chk("async_rst", {BUSY, DONE, REJECT, SRC_EN, DST_EN, DST_WE},
        6'b0);
    chk("async_rst_addr", {SRC_ADDR, DST_ADDR, COPY_COUNT}, 44'h0);
    tick();
    RESET = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (BUSY || DONE || SRC_EN || DST_EN) bad++;
    end
    chk("post_rst_idle", bad, 0);

    mon_clear(1, 1, 1);
    START = 1'b1; FRAME_SEL = 2'd1; DST_READY = 1'b1;
    tick();
    START = 1'b0;
    k = 0;
    while (SRC_ADDR !== 12'h464 && k < 200) begin
      tick();
      k++;
    end
    chk("abort_reach", k < 200, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_outs", {BUSY, DONE, SRC_EN, DST_EN, DST_WE}, 5'b0);
    bad = 0;
    repeat (8) begin
      tick();
      if (BUSY || DONE || SRC_EN || DST_EN) bad++;
    end
    chk("abort_quiet", bad, 0);
    chk("abort_rd_wr", {rd_cnt[15:0], wr_cnt[15:0]}, {16'd101, 16'd100});
    chk("abort_cnt", COPY_COUNT, 0);
    do_copy(1, "f1_after_abort");

    mon_clear(3, 0, 3);
    START = 1'b1; FRAME_SEL = 2'd3; DST_READY = 1'b1;
    tick();
    chk("b2b_first", SRC_ADDR, 12'hC00);
    wait_done(k);
    chk("b2b_done1", k, 1026);
    FRAME_SEL = 2'd0;
    tick();
    START = 1'b0;
    chk("b2b_second", {SRC_EN, 3'b0, SRC_ADDR}, 16'h8000);
    wait_done(k);
    chk("b2b_done2", k, 1026);
    chk("b2b_rd_wr", {rd_cnt[15:0], wr_cnt[15:0]},
        {16'd2048, 16'd2048});
    chk("b2b_seq_err", rd_err + wr_err + dat_err, 0);
    chk("copy_count", COPY_COUNT, 32'(CNT_EN * 3));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
